// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: widths and
// requester indices.
package rf_pkg;
    localparam int DSIZE = 16;
    localparam int NREG  = 16;
    localparam int RSIZE = 4;
    localparam int NREQ  = 3;

    localparam int LINK = 0;
    localparam int MEM  = 1;
    localparam int ALU  = 2;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: three requesters, pending-set port, hazard-check port and
// register-file write port. The arbiter sits on the slave side.
interface rf_wb_arbiter_if #(
    parameter int DSIZE = rf_pkg::DSIZE
) ();
    import rf_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*RSIZE-1:0] req_addr;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    logic                  pend_set;
    logic [RSIZE-1:0]      pend_addr;
    logic [RSIZE-1:0]      chk_addr1;
    logic [RSIZE-1:0]      chk_addr2;
    logic                  busy1;
    logic                  busy2;

    logic                  rf_wen;
    logic [RSIZE-1:0]      rf_waddr;
    logic [DSIZE-1:0]      rf_wdata;
    logic                  idle;

    modport master (
        output req_valid, req_addr, req_data, pend_set, pend_addr, chk_addr1, chk_addr2,
        input  req_ready, busy1, busy2, rf_wen, rf_waddr, rf_wdata, idle
    );

    modport slave (
        input  req_valid, req_addr, req_data, pend_set, pend_addr, chk_addr1, chk_addr2,
        output req_ready, busy1, busy2, rf_wen, rf_waddr, rf_wdata, idle
    );
endinterface

// File: rtl/rf_wb_arbiter_rr_arb3.sv
// Three-way round-robin grant: first asserted request searching upward
// from ptr, wrapping at 3. Purely combinational.
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);
    logic w_found;
    int   w_idx;

    // ptr==3 is never produced; (3+k)%3 degrades gracefully to ptr==0 order.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < 3; k++) begin
            w_idx = (int'(ptr) + k) % 3;
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: round-robin selection of one register-file write per
// cycle, registered write port, and a pending scoreboard for hazard checks.
module rf_wb_arbiter #(
    parameter int DSIZE = rf_pkg::DSIZE,
    parameter int NREG  = rf_pkg::NREG
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);
    import rf_pkg::*;

    logic [1:0]       r_ptr;
    logic [NREG-1:0]  r_pend;
    logic             r_wen;
    logic [RSIZE-1:0] r_waddr;
    logic [DSIZE-1:0] r_wdata;

    logic [NREQ-1:0]  w_grant;
    logic [NREQ-1:0]  w_xfer;
    logic             w_any;
    logic [1:0]       w_ptr_nxt;
    logic [RSIZE-1:0] w_addr;
    logic [DSIZE-1:0] w_data;
    logic [NREG-1:0]  w_pend_nxt;
    logic             w_busy1;
    logic             w_busy2;

    rr_arb3 u_arb (
        .req   (bus.req_valid),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    // Nothing is granted while reset is held, so no transfer can slip in.
    assign bus.req_ready = rst ? '0 : w_grant;
    assign w_xfer        = bus.req_valid & bus.req_ready;
    assign w_any         = |w_xfer;

    always_comb begin
        w_addr    = '0;
        w_data    = '0;
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (w_xfer[i]) begin
                w_addr    = bus.req_addr[i*RSIZE +: RSIZE];
                w_data    = bus.req_data[i*DSIZE +: DSIZE];
                w_ptr_nxt = 2'((i + 1) % NREQ);
            end
        end
    end

    // A set wins over a same-cycle clear of the same bit.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < NREG; i++) begin
            if (r_wen && int'(r_waddr) == i)
                w_pend_nxt[i] = 1'b0;
            if (bus.pend_set && bus.pend_addr != '0 && int'(bus.pend_addr) == i)
                w_pend_nxt[i] = 1'b1;
        end
    end

    // Bypass: a register being written this cycle is no longer a hazard.
    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (int'(bus.chk_addr1) == i)
                w_busy1 = r_pend[i] && !(r_wen && r_waddr == bus.chk_addr1);
            if (int'(bus.chk_addr2) == i)
                w_busy2 = r_pend[i] && !(r_wen && r_waddr == bus.chk_addr2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_pend  <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_pend <= w_pend_nxt;
            r_wen  <= w_any && (w_addr != '0);
            if (w_any) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
        end
    end

    assign bus.rf_wen   = r_wen;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;
    assign bus.busy1    = w_busy1;
    assign bus.busy2    = w_busy2;
    assign bus.idle     = (r_pend == '0) && !r_wen;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, r0 drop, pending
// scoreboard bypass/set-wins, and mid-operation reset.
module tb_rf_wb_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] v,
                           input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                           input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        bus.req_valid = v;
        bus.req_addr  = {a2, a1, a0};
        bus.req_data  = {d2, d1, d0};
        #1;
    endtask

    task automatic test_reset();
        bus.pend_set  = 1'b0;
        bus.pend_addr = 4'd0;
        bus.chk_addr1 = 4'd0;
        bus.chk_addr2 = 4'd0;
        rst = 1'b1;
        set_req(3'b111, 4'd1, 4'd2, 4'd3, 16'h1, 16'h2, 16'h3);
        tick();
        n_chk++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b want 000", bus.req_ready); end
        tick();
        rst = 1'b0;
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        n_chk++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b want 0", bus.rf_wen); end
        n_chk++; if (bus.rf_waddr !== 4'd0) begin n_fail++; $display("FAIL rst_waddr: got %h want 0", bus.rf_waddr); end
        n_chk++; if (bus.rf_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", bus.rf_wdata); end
        n_chk++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", bus.idle); end
        n_chk++; if ({bus.busy1, bus.busy2} !== 2'b00) begin n_fail++; $display("FAIL rst_busy: got %b want 00", {bus.busy1, bus.busy2}); end
    endtask

    // ptr 0 -> link, mem, alu on consecutive cycles; writes land one cycle later.
    task automatic test_three_way();
        set_req(3'b111, 4'd1, 4'd2, 4'd3, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rr3_g0: got %b want 001", bus.req_ready); end
        tick();
        set_req(3'b110, 4'd1, 4'd2, 4'd3, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL rr3_g1: got %b want 010", bus.req_ready); end
        n_chk++; if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 4'd1, 16'hAAAA}) begin n_fail++; $display("FAIL rr3_w1: got %b/%h/%h want 1/1/aaaa", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        tick();
        set_req(3'b100, 4'd1, 4'd2, 4'd3, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        n_chk++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL rr3_g2: got %b want 100", bus.req_ready); end
        n_chk++; if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 4'd2, 16'hBBBB}) begin n_fail++; $display("FAIL rr3_w2: got %b/%h/%h want 1/2/bbbb", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        tick();
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        n_chk++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL rr3_none: got %b want 000", bus.req_ready); end
        n_chk++; if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 4'd3, 16'hCCCC}) begin n_fail++; $display("FAIL rr3_w3: got %b/%h/%h want 1/3/cccc", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        tick();
        n_chk++; if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 4'd3, 16'hCCCC}) begin n_fail++; $display("FAIL hold_after_idle: got %b/%h/%h want 0/3/cccc", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        n_chk++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL rr3_idle: got %b want 1", bus.idle); end
    endtask

    // ptr is 0 here; alu to r0 is consumed silently and moves ptr back to 0.
    task automatic test_r0_write();
        set_req(3'b100, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'hFFFF);
        n_chk++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL r0_ready: got %b want 100", bus.req_ready); end
        tick();
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        n_chk++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL r0_wen: got %b want 0", bus.rf_wen); end
        n_chk++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL r0_pend: idle got %b want 1", bus.idle); end
        bus.pend_set = 1'b1; bus.pend_addr = 4'd0;
        tick();
        bus.pend_set = 1'b0;
        #1;
        n_chk++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL pend_r0_ignored: idle got %b want 1", bus.idle); end
    endtask

    // ptr is 0: r5 pending, busy1 through the write cycle via bypass.
    task automatic test_pend_bypass();
        bus.chk_addr1 = 4'd5;
        bus.pend_set = 1'b1; bus.pend_addr = 4'd5;
        tick();
        bus.pend_set = 1'b0;
        set_req(3'b010, 4'd0, 4'd5, 4'd0, 16'h0, 16'h1234, 16'h0);
        n_chk++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL pend_busy_pre: got %b want 1", bus.busy1); end
        n_chk++; if (bus.idle !== 1'b0) begin n_fail++; $display("FAIL pend_idle_pre: got %b want 0", bus.idle); end
        n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL pend_ready: got %b want 010", bus.req_ready); end
        tick();
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        n_chk++; if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 4'd5, 16'h1234}) begin n_fail++; $display("FAIL pend_write: got %b/%h/%h want 1/5/1234", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        n_chk++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL pend_busy_wen: got %b want 0", bus.busy1); end
        tick();
        n_chk++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL pend_busy_post: got %b want 0", bus.busy1); end
        n_chk++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL pend_idle_post: got %b want 1", bus.idle); end
    endtask

    // ptr is 2 after the mem write above; mem still wins as only requester.
    task automatic test_set_wins();
        bus.chk_addr2 = 4'd7;
        set_req(3'b010, 4'd0, 4'd7, 4'd0, 16'h0, 16'h7777, 16'h0);
        tick();
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        bus.pend_set = 1'b1; bus.pend_addr = 4'd7;
        #1;
        n_chk++; if ({bus.rf_wen, bus.rf_waddr} !== {1'b1, 4'd7}) begin n_fail++; $display("FAIL sw_write: got %b/%h want 1/7", bus.rf_wen, bus.rf_waddr); end
        tick();
        bus.pend_set = 1'b0;
        #1;
        n_chk++; if (bus.busy2 !== 1'b1) begin n_fail++; $display("FAIL sw_busy: got %b want 1", bus.busy2); end
        n_chk++; if (bus.idle !== 1'b0) begin n_fail++; $display("FAIL sw_idle: got %b want 0", bus.idle); end
        set_req(3'b010, 4'd0, 4'd7, 4'd0, 16'h0, 16'h7778, 16'h0);
        tick();
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        tick();
        n_chk++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL sw_drain: idle got %b want 1", bus.idle); end
    endtask

    // ptr is 2: wrap order 2,0,1 then 1,2,0.
    task automatic test_rr_wrap();
        set_req(3'b011, 4'd8, 4'd9, 4'd0, 16'h0008, 16'h0009, 16'h0);
        n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL wrap_p2: got %b want 001", bus.req_ready); end
        tick();
        set_req(3'b110, 4'd8, 4'd9, 4'd10, 16'h0008, 16'h0009, 16'h000A);
        n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL wrap_p1: got %b want 010", bus.req_ready); end
        tick();
        set_req(3'b101, 4'd11, 4'd0, 4'd10, 16'h000B, 16'h0, 16'h000A);
        n_chk++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL wrap_p2b: got %b want 100", bus.req_ready); end
        tick();
        set_req(3'b001, 4'd11, 4'd0, 4'd0, 16'h000B, 16'h0, 16'h0);
        n_chk++; if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 4'd10, 16'h000A}) begin n_fail++; $display("FAIL wrap_write: got %b/%h/%h want 1/a/000a", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL wrap_p0: got %b want 001", bus.req_ready); end
        tick();
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        tick();
    endtask

    // ptr is 1 here; reset must discard the mem grant and clear ptr/pend.
    task automatic test_reset_mid();
        bus.pend_set = 1'b1; bus.pend_addr = 4'd4;
        tick();
        bus.pend_set = 1'b0;
        set_req(3'b010, 4'd0, 4'd4, 4'd0, 16'h0, 16'h4444, 16'h0);
        n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL rm_ready_pre: got %b want 010", bus.req_ready); end
        rst = 1'b1;
        #1;
        n_chk++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL rm_ready_rst: got %b want 000", bus.req_ready); end
        tick();
        rst = 1'b0;
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        n_chk++; if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 4'd0, 16'h0}) begin n_fail++; $display("FAIL rm_write: got %b/%h/%h want 0/0/0000", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        n_chk++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL rm_idle: got %b want 1", bus.idle); end
        tick();
        n_chk++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL rm_late_write: got %b want 0", bus.rf_wen); end
        set_req(3'b101, 4'd12, 4'd0, 4'd13, 16'h000C, 16'h0, 16'h000D);
        n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rm_ptr0: got %b want 001", bus.req_ready); end
        tick();
        set_req(3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        test_reset();
        test_three_way();
        test_r0_write();
        test_pend_bypass();
        test_set_wins();
        test_rr_wrap();
        test_reset_mid();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
